// File: rtl/delay_line_ctrl.sv
// Run-time programmable delay line for the signed sample path, with a FILL/RUN sequencer.
// Latency: exactly cur_delay cycles (1..DEPTH) for data and valid; registered outputs.
// No backpressure: accepts one sample per cycle; outputs masked while refilling.
//
// Ports:
//   clk, reset       - clock; synchronous active-high reset
//   cfg_load         - one-cycle request to apply cfg_delay (legal 1..DEPTH)
//   in_valid/data_in - qualifier and signed input sample
//   data_out/out_valid - delayed sample and qualifier (zero while busy)
//   busy             - high while in FILL
//   cfg_err          - one-cycle pulse after a rejected cfg_load
module delay_line_ctrl #(
    parameter int DATA_W      = 25,
    parameter int PTR_W       = 4,
    parameter int RESET_DELAY = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_load,
    input  logic [PTR_W:0]           cfg_delay,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] data_in,
    output logic signed [DATA_W-1:0] data_out,
    output logic                     out_valid,
    output logic                     busy,
    output logic                     cfg_err
);

    localparam int DEPTH = 1 << PTR_W;

    localparam logic [PTR_W:0]   DLY_ONE = {{PTR_W{1'b0}}, 1'b1};
    localparam logic [PTR_W:0]   DLY_MAX = {1'b1, {PTR_W{1'b0}}};
    localparam logic [PTR_W:0]   RST_DLY = RESET_DELAY[PTR_W:0];
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic                     vld;
        logic signed [DATA_W-1:0] dat;
    } entry_t;

    typedef enum logic {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_t;

    entry_t         mem [DEPTH];
    state_t         state;
    state_t         state_nxt;
    logic [PTR_W:0] cur_delay;
    logic [PTR_W:0] delay_nxt;
    logic [PTR_W:0] fill_cnt;
    logic [PTR_W:0] fill_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic           cfg_in_range;
    logic           cfg_ok;
    entry_t         sel;

    assign cfg_in_range = (cfg_delay != '0) && (cfg_delay <= DLY_MAX);
    assign cfg_ok       = cfg_load && cfg_in_range;

    // Offset is (cur_delay - 1) mod DEPTH; using only the low bits keeps
    // delay == DEPTH correct (low bits 0 -> offset DEPTH-1, the oldest slot).
    assign rd_ptr = wr_ptr - (cur_delay[PTR_W-1:0] - PTR_ONE);

    // Delay of one means the sample being written this cycle is the one to
    // present next, so it bypasses the buffer.
    always_comb begin
        sel = mem[rd_ptr];
        if (cur_delay == DLY_ONE) begin
            sel = {in_valid, data_in};
        end
    end

    always_comb begin
        state_nxt = state;
        delay_nxt = cur_delay;
        fill_nxt  = fill_cnt;
        case (state)
            FILL: begin
                fill_nxt = fill_cnt + DLY_ONE;
                if (fill_cnt == cur_delay - DLY_ONE) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                state_nxt = RUN;
            end
            default: begin
                state_nxt = FILL;
            end
        endcase
        // An accepted load restarts the fill window from this cycle.
        if (cfg_ok) begin
            state_nxt = FILL;
            delay_nxt = cfg_delay;
            fill_nxt  = '0;
        end
    end

    // Buffer is never cleared; FILL masking hides whatever it holds.
    always_ff @(posedge clk) begin
        mem[wr_ptr] <= {in_valid, data_in};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= FILL;
            cur_delay <= RST_DLY;
            fill_cnt  <= '0;
            wr_ptr    <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_delay <= delay_nxt;
            fill_cnt  <= fill_nxt;
            wr_ptr    <= wr_ptr + PTR_ONE;
            cfg_err   <= cfg_load && !cfg_in_range;
            // Outputs follow the state being entered so they are registered
            // yet aligned with busy.
            if (state_nxt == RUN) begin
                data_out  <= sel.dat;
                out_valid <= sel.vld;
            end else begin
                data_out  <= '0;
                out_valid <= 1'b0;
            end
        end
    end

    assign busy = (state == FILL);

endmodule
